// File: rtl/sd_resp_pkg.sv
// Shared state encoding, sector geometry and request record for the sector responder.
package sd_resp_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int GAP_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE, DELAY, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, GAP
  } sd_state_e;

  typedef struct packed {
    logic        rd;
    logic [31:0] lba;
  } sd_req_t;
endpackage

// File: rtl/sd_sector_responder_if.sv
// Virtual-disk sector handshake plus backing-memory port; slave is the responder side.
interface sd_sector_responder_if #(
  parameter int VDNUM  = 2,
  parameter int MEM_AW = 20
);
  logic [VDNUM-1:0][31:0] sd_lba;
  logic [VDNUM-1:0]       sd_rd;
  logic [VDNUM-1:0]       sd_wr;
  logic [VDNUM-1:0]       sd_ack;
  logic [8:0]             sd_buff_addr;
  logic [7:0]             sd_buff_dout;
  logic [VDNUM-1:0][7:0]  sd_buff_din;
  logic                   sd_buff_wr;
  logic [MEM_AW-1:0]      mem_addr;
  logic                   mem_rd;
  logic [7:0]             mem_rdata;
  logic                   mem_we;
  logic [7:0]             mem_wdata;
  logic                   busy;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_we, mem_wdata, busy
  );
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/sd_resp_arb.sv
// Lowest-index-wins request picker; read beats write within one unit.
module sd_resp_arb #(
  parameter int VDNUM = 2,
  parameter int UW    = 1
) (
  input  logic [VDNUM-1:0] rd_i,
  input  logic [VDNUM-1:0] wr_i,
  output logic             vld_o,
  output logic [UW-1:0]    unit_o,
  output logic             rd_o
);
  always_comb begin
    vld_o  = 1'b0;
    unit_o = '0;
    rd_o   = 1'b0;
    // Scan downward so the lowest requesting unit is the last assignment.
    for (int i = VDNUM - 1; i >= 0; i--) begin
      if (rd_i[i] | wr_i[i]) begin
        vld_o  = 1'b1;
        unit_o = UW'(i);
        rd_o   = rd_i[i];
      end
    end
  end
endmodule

// File: rtl/sd_sector_responder.sv
// Serves whole-sector reads/writes from VDNUM disk initiators out of a 1-cycle backing memory.
// Optional SD_RESP_DELAY_EN inserts ACK_DELAY (>=1) idle cycles before each ack.
module sd_sector_responder
  import sd_resp_pkg::*;
#(
  parameter int VDNUM     = 2,
  parameter int MEM_AW    = 20,
  parameter int ACK_DELAY = 16
) (
  input logic                  clk_sys,
  input logic                  reset_n,
  sd_sector_responder_if.slave bus
);
  localparam int UW = (VDNUM > 1) ? $clog2(VDNUM) : 1;
  localparam int LW = MEM_AW - 9;

  if (VDNUM < 1 || VDNUM > 4 || ACK_DELAY < 0) begin : g_bad_param
    $error("sd_sector_responder: unsupported parameters");
  end

  sd_state_e        state_q;
  logic [VDNUM-1:0] ack_q;
  logic [8:0]       cnt_q, buff_addr_q;
  logic             buff_wr_q, rd_pass_q, mem_rd_q, mem_we_q, busy_q, ok_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]       wdata_q;
  logic [LW-1:0]    sec_q;
  logic [UW-1:0]    unit_q;
  logic [1:0]       gap_q;

  logic             arb_vld, arb_rd, start, s_ok, last;
  logic [UW-1:0]    arb_unit, s_unit;
  sd_req_t          s_req;

  sd_resp_arb #(.VDNUM(VDNUM), .UW(UW)) u_arb (
    .rd_i(bus.sd_rd), .wr_i(bus.sd_wr),
    .vld_o(arb_vld), .unit_o(arb_unit), .rd_o(arb_rd)
  );

`ifdef SD_RESP_DELAY_EN
  sd_req_t     req_q;
  logic [15:0] dly_q;
  assign start  = (state_q == DELAY) && (dly_q == 16'(ACK_DELAY - 1));
  assign s_req  = req_q;
  assign s_unit = unit_q;
`else
  assign start  = (state_q == IDLE) && arb_vld;
  assign s_req  = '{rd: arb_rd, lba: bus.sd_lba[arb_unit]};
  assign s_unit = arb_unit;
`endif

  assign s_ok = ~|(s_req.lba >> LW);
  assign last = (cnt_q == 9'(SECTOR_BYTES - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      cnt_q       <= '0;
      buff_addr_q <= '0;
      buff_wr_q   <= 1'b0;
      rd_pass_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      sec_q       <= '0;
      unit_q      <= '0;
      gap_q       <= '0;
`ifdef SD_RESP_DELAY_EN
      req_q       <= '0;
      dly_q       <= '0;
`endif
    end else begin
      buff_wr_q <= 1'b0;
      rd_pass_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      if (start) begin
        state_q     <= s_req.rd ? RD_ADDR : WR_ADDR;
        ack_q       <= VDNUM'(1) << s_unit;
        unit_q      <= s_unit;
        ok_q        <= s_ok;
        sec_q       <= s_req.lba[LW-1:0];
        cnt_q       <= '0;
        buff_addr_q <= '0;
        busy_q      <= 1'b1;
        mem_rd_q    <= s_req.rd & s_ok;
        mem_addr_q  <= {s_req.lba[LW-1:0], 9'd0};
      end else begin
        case (state_q)
`ifdef SD_RESP_DELAY_EN
          IDLE: if (arb_vld) begin
            state_q <= DELAY;
            busy_q  <= 1'b1;
            unit_q  <= arb_unit;
            req_q   <= '{rd: arb_rd, lba: bus.sd_lba[arb_unit]};
            dly_q   <= '0;
          end
          DELAY: dly_q <= dly_q + 16'd1;
`endif
          RD_ADDR: begin
            state_q     <= RD_DATA;
            buff_wr_q   <= 1'b1;
            buff_addr_q <= cnt_q;
            rd_pass_q   <= ok_q;
          end
          RD_DATA: if (last) begin
            state_q <= GAP;
            ack_q   <= '0;
            gap_q   <= '0;
          end else begin
            state_q    <= RD_ADDR;
            cnt_q      <= cnt_q + 9'd1;
            mem_rd_q   <= ok_q;
            mem_addr_q <= {sec_q, cnt_q + 9'd1};
          end
          WR_ADDR: state_q <= WR_DATA;
          WR_DATA: begin
            // Commit lands one cycle later, overlapping the next byte's address phase.
            wdata_q    <= bus.sd_buff_din[unit_q];
            mem_we_q   <= ok_q;
            mem_addr_q <= {sec_q, cnt_q};
            if (last) begin
              state_q <= GAP;
              ack_q   <= '0;
              gap_q   <= '0;
            end else begin
              state_q     <= WR_ADDR;
              cnt_q       <= cnt_q + 9'd1;
              buff_addr_q <= cnt_q + 9'd1;
            end
          end
          GAP: if (gap_q == 2'(GAP_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sd_ack       = ack_q;
  assign bus.sd_buff_addr = buff_addr_q;
  assign bus.sd_buff_wr   = buff_wr_q;
  // Memory output is already a register; forward it during the strobe cycle only.
  assign bus.sd_buff_dout = rd_pass_q ? bus.mem_rdata : 8'h00;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench: memory + initiator models, expected read bytes queued at request time.
module tb_sd_sector_responder;
  localparam int VDNUM = 2, MEM_AW = 20, ACK_DELAY = 16;
  localparam int NSEC  = 2 ** (MEM_AW - 9);
`ifdef SD_RESP_DELAY_EN
  localparam int LAT = 1 + ACK_DELAY;
`else
  localparam int LAT = 1;
`endif
  localparam int GAPT = 1026 + LAT;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  sd_sector_responder_if #(.VDNUM(VDNUM), .MEM_AW(MEM_AW)) bus ();
  sd_sector_responder #(.VDNUM(VDNUM), .MEM_AW(MEM_AW), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus.slave)
  );

  typedef struct { int u; bit rd; logic [31:0] lba; } xfer_t;
  typedef struct { logic [8:0] a; logic [7:0] d; } exp_t;
  xfer_t lq[$];
  exp_t  eq[$];
  xfer_t cur;

  logic [7:0] mem  [NSEC*512];
  logic [7:0] ibuf [VDNUM][512];
  int cyc = 0, errs = 0, nchk = 0;
  int ack_t = 0, n_str = 0, n_mrd = 0;
  logic [VDNUM-1:0] ack_d = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    for (int u = 0; u < VDNUM; u++) bus.sd_buff_din[u] <= ibuf[u][bus.sd_buff_addr];
  end

  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n) begin
      if (bus.sd_ack != '0 && ack_d == '0) begin
        ack_t = cyc; n_str = 0; n_mrd = 0;
        if (lq.size() == 0) chk("ack_unexpected", bus.sd_ack, 0);
        else begin
          cur = lq.pop_front();
          chk("ack_unit", bus.sd_ack, 1 << cur.u);
        end
      end
      if (bus.sd_ack == '0 && ack_d != '0) begin
        chk("ack_len", cyc - ack_t, 1024);
        chk("strobes", n_str, cur.rd ? 512 : 0);
        chk("mem_rds", n_mrd, (cur.rd && cur.lba < NSEC) ? 512 : 0);
      end
      if (bus.sd_buff_wr) begin
        n_str++;
        if (eq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = eq.pop_front();
          chk("rd_addr", bus.sd_buff_addr, e.a);
          chk("rd_data", bus.sd_buff_dout, e.d);
          chk("rd_time", cyc - ack_t, 1 + 2 * e.a);
        end
      end
      if (bus.mem_rd) begin
        n_mrd++;
        chk("mrd_in_range", cur.lba < NSEC, 1);
        chk("mrd_addr", bus.mem_addr, {cur.lba[MEM_AW-10:0], 9'((cyc - ack_t) / 2)});
      end
      if (bus.mem_we) begin
        chk("mwe_in_range", cur.lba < NSEC, 1);
        chk("mwe_sector", bus.mem_addr[MEM_AW-1:9], cur.lba[MEM_AW-10:0]);
        chk("mwe_time", cyc - ack_t, 2 + 2 * bus.mem_addr[8:0]);
      end
    end
    ack_d = bus.sd_ack;
  end

  task automatic req(input int u, input bit rd, input logic [31:0] lba);
    xfer_t x;
    exp_t  e;
    x.u = u; x.rd = rd; x.lba = lba;
    lq.push_back(x);
    if (rd) for (int i = 0; i < 512; i++) begin
      e.a = 9'(i);
      e.d = (lba < NSEC) ? (8'(i) ^ 8'h5A) : 8'h00;
      eq.push_back(e);
    end
    bus.sd_lba[u] = lba;
    if (rd) bus.sd_rd[u] = 1'b1; else bus.sd_wr[u] = 1'b1;
  endtask

  task automatic drop(input int u);
    bus.sd_rd[u] = 1'b0;
    bus.sd_wr[u] = 1'b0;
  endtask

  task automatic wait_rise(input int u, output int t);
    bit seen_low;
    seen_low = !bus.sd_ack[u];
    t = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_sys);
      if (!bus.sd_ack[u]) seen_low = 1'b1;
      else if (seen_low) begin t = cyc; break; end
    end
    if (t < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_sys);
      if (!bus.busy && bus.sd_ack == '0) begin done = 1'b1; break; end
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset();
    chk("rst_ack", bus.sd_ack, 0);
    chk("rst_buff_addr", bus.sd_buff_addr, 0);
    chk("rst_buff_dout", bus.sd_buff_dout, 0);
    chk("rst_buff_wr", bus.sd_buff_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tp, c0;
    bit got;
    bus.sd_rd  = '0;
    bus.sd_wr  = '0;
    bus.sd_lba = '0;
    for (int k = 0; k < NSEC * 512; k++) mem[k] = 8'(k) ^ 8'h5A;
    for (int i = 0; i < 512; i++) begin
      ibuf[0][i] = 8'(i) ^ 8'h33;
      ibuf[1][i] = 8'hFF - 8'(i);
    end
    repeat (3) @(negedge clk_sys);
    check_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // single-sector read, unit 0, lba 3
    c0 = cyc;
    req(0, 1'b1, 32'd3);
    wait_rise(0, t);
    chk("ack_latency", t - c0, LAT);
    drop(0);
    wait_idle();

    // write, unit 1, lba 0
    req(1, 1'b0, 32'd0);
    wait_rise(1, t);
    drop(1);
    wait_idle();
    for (int i = 0; i < 512; i++) chk("wr_mem", mem[i], 8'hFF - 8'(i));

    // simultaneous reads: unit 0 first, unit 1 after the gap
    req(0, 1'b1, 32'd10);
    req(1, 1'b1, 32'd11);
    wait_rise(0, tp);
    drop(0);
    wait_rise(1, t);
    drop(1);
    chk("simul_gap", t - tp, GAPT);
    wait_idle();

    // streaming: rd held across 13 sectors, lba bumped on every ack rise
    req(0, 1'b1, 32'd26);
    tp = 0;
    for (int k = 1; k <= 13; k++) begin
      wait_rise(0, t);
      if (k > 1) chk("stream_gap", t - tp, GAPT);
      tp = t;
      if (k < 13) req(0, 1'b1, 32'(26 + k)); else drop(0);
    end
    wait_idle();

    // out of range read then write
    req(0, 1'b1, NSEC);
    wait_rise(0, t);
    drop(0);
    wait_idle();
    req(0, 1'b0, NSEC);
    wait_rise(0, t);
    drop(0);
    wait_idle();
    for (int i = 0; i < 512; i++) chk("oor_wr_no_alias", mem[i], 8'hFF - 8'(i));

    // reset at byte 200 of a read, then a clean read
    req(0, 1'b1, 32'd5);
    wait_rise(0, t);
    drop(0);
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_sys);
      if (bus.sd_buff_wr && bus.sd_buff_addr == 9'd200) begin got = 1'b1; break; end
    end
    chk("reach_byte_200", got, 1);
    #1 reset_n = 1'b0;
    #1 check_reset();
    eq.delete();
    lq.delete();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    c0 = cyc;
    req(0, 1'b1, 32'd7);
    wait_rise(0, t);
    chk("post_reset_latency", t - c0, LAT);
    drop(0);
    wait_idle();
    chk("scoreboard_drained", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/sd_sector_responder.md
# sd_sector_responder

Responder end of the virtual-disk sector handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*) used by the core's floppy and HDD controllers. It answers sector read and write requests from up to VDNUM initiators. Requests are served from a single-cycle-latency backing memory, for example an on-chip RAM disk or a simulation disk model. It sits between the disk controllers and the memory, replacing the HPS-side server when a standalone or testbench image is used.

## Interface
Parameters:
- VDNUM, 2, number of virtual-disk units (1..4)
- MEM_AW, 20, backing memory byte-address width; capacity is 2^(MEM_AW-9) sectors
- ACK_DELAY, 16, idle cycles inserted before ack (used only with SD_RESP_DELAY_EN)

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- sd_lba  in  [VDNUM] x 32  sector number per unit
- sd_rd  in  VDNUM  read request per unit, level
- sd_wr  in  VDNUM  write request per unit, level
- sd_ack  out  VDNUM  one-hot acknowledge; high for the whole transfer
- sd_buff_addr  out  9  byte index within the sector
- sd_buff_dout  out  8  read data toward the initiator
- sd_buff_din  in  [VDNUM] x 8  write data from the initiator; registered, valid 1 cycle after sd_buff_addr
- sd_buff_wr  out  1  one-cycle strobe; sd_buff_dout is valid at sd_buff_addr
- mem_addr  out  MEM_AW  backing memory byte address
- mem_rd  out  1  memory read; mem_rdata is valid the next cycle
- mem_rdata  in  8  memory read data
- mem_we  out  1  memory write strobe
- mem_wdata  out  8  memory write data
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, DELAY, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, GAP.
- IDLE:
  - Selects the lowest-index unit u with sd_rd[u] or sd_wr[u]. If both are high for u, read wins.
  - Latches unit, direction and sd_lba[u] in the accepting cycle.
  - Next state is RD_ADDR or WR_ADDR; with the macro enabled, DELAY comes first.
- sd_ack[u] rises on entry to RD_ADDR or WR_ADDR and stays high through the last byte.
- Initiators may drop rd/wr or change lba any time after the ack rising edge. The latched values are used.
- base = {lba[MEM_AW-10:0], 9'd0}.
- Out of range (lba >= 2^(MEM_AW-9)):
  - Reads return 0x00 with mem_rd suppressed.
  - Writes are dropped with mem_we suppressed.
  - The handshake itself is unchanged.
- Read: byte counter i runs 0..511. RD_ADDR drives mem_rd, mem_addr = base+i. RD_DATA presents sd_buff_addr=i, sd_buff_dout=mem_rdata, sd_buff_wr=1.
- Write:
  - WR_ADDR drives sd_buff_addr=i.
  - WR_DATA holds sd_buff_addr=i and captures sd_buff_din[u].
  - The cycle after WR_DATA drives mem_we with mem_addr=base+i, mem_wdata=captured byte, overlapped with the next WR_ADDR.
- After byte 511 the FSM enters GAP: sd_ack drops and the FSM stays 2 cycles, then returns to IDLE.
- A request still held high is served again as a new sector with a freshly latched lba. This supports multi-sector streaming, where the initiator holds rd and increments lba at each ack rise.
- Asserting reset_n low at any point aborts the transfer immediately. No partial-sector commit is guaranteed.

## Timing
- Reset values: sd_ack=0, sd_buff_addr=0, sd_buff_dout=0, sd_buff_wr=0, mem_addr=0, mem_rd=0, mem_we=0, mem_wdata=0, busy=0, state IDLE.
- Request seen in IDLE cycle R: ack is high from R+1 (R+1+ACK_DELAY with the macro).
- Ack first high at cycle A:
  - Read: byte i has mem_rd at A+2i and sd_buff_wr at A+1+2i.
  - Write: byte i has sd_buff_addr set at A+2i and mem_we at A+2+2i.
  - Last read strobe falls at A+1023; the last write mem_we occurs at A+1024.
  - Ack is low at A+1024 for both directions.
- Earliest next ack for any unit: A+1027.
- All outputs are registered.

## Configuration
- SD_RESP_DELAY_EN defined: the DELAY state counts ACK_DELAY cycles before ack, to emulate HPS latency. Requests are not re-arbitrated during DELAY.
- Not defined: the DELAY state, its counter and the ACK_DELAY parameter have no effect. Ack rises 1 cycle after acceptance.

## Structure
- Package sd_resp_pkg holds:
  - the state enum
  - SECTOR_BYTES=512
  - GAP_CYCLES=2
- Sub-module sd_resp_arb: combinational lowest-index priority picker, VDNUM-wide. It outputs a valid flag, the unit index and the direction.

## Test plan
- Read, single sector:
  - Stimulus: mem preloaded with byte k = k[7:0] ^ 8'h5A; unit 0 sd_rd with lba=3.
  - Response: 512 strobes, addr 0..511, dout = mem[1536+i], 2 cycles apart; ack high for 1024 cycles.
- Write:
  - Stimulus: unit 1 sd_wr with lba=0; initiator buffer holds 8'hFF-i.
  - Response: mem[i] = 8'hFF-i for i=0..511; ack only on bit 1.
- Simultaneous requests:
  - Stimulus: sd_rd on units 0 and 1 in the same cycle.
  - Response: unit 0 is served first; unit 1 is acked at A+1027.
- Streaming:
  - Stimulus: fdd-style initiator holds rd across 13 sectors, incrementing lba 26..38 on each ack rise.
  - Response: 13 back-to-back sectors with correct data each.
- Out of range:
  - Stimulus: lba = 2^(MEM_AW-9) on read, then on write.
  - Response: the read returns all 0x00 with mem_rd never high; the write shows no mem_we; both complete a normal handshake.
- Reset mid-transfer:
  - Stimulus: reset_n low at byte 200 of a read.
  - Response: all outputs return to reset values asynchronously. After release, a new request is served normally.
